// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Mid-bit sampling is driven by a single cycle counter that is phase-aligned on the start-bit falling edge.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);
  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_DIV - 1);

  generate
    if (BAUD_DIV < 4) begin : g_bad_baud_div
      $error("uart_rx: CLK_FREQUENCY/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  // Synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BAUD_M1) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BAUD_M1) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Sampling mid-stop-bit returns to IDLE early enough to catch a back-to-back start bit.
          if (cnt == BAUD_M1) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) begin
              frame_error <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (^{shift, par_bit}) begin
              parity_error <= 1'b1;
            end
`endif
            else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 10 clocks per bit.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the 8E1 build.
module tb_uart_rx;
  localparam int BD   = 10;
  localparam int HALF = 5;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int LAT = 2 + HALF + (NBITS - 1) * BD;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  uart_rx #(
    .CLK_FREQUENCY(1_000_000),
    .BAUD_RATE    (100_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor counts high cycles, so a pulse wider than one cycle shows up as an extra count.
  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0, n_overlap = 0;
  logic [7:0] vdata [0:31];
  int         vcyc  [0:31];
  always @(negedge clk) begin
    if (rx_valid) begin
      vdata[n_valid % 32] = rx_data;
      vcyc[n_valid % 32]  = cyc;
      n_valid++;
    end
    if (frame_error) n_ferr++;
    if (parity_error) n_perr++;
    if (busy) n_busy++;
    if (int'(rx_valid) + int'(frame_error) + int'(parity_error) > 1) n_overlap++;
  end

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int fall_cyc;

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit((^d) ^ par_flip);
    send_bit(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * BD) @(negedge clk);
  endtask

  int         v0, f0, p0, b0, lat, gap;
  logic [7:0] d77;

  initial begin
    rst       = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_parity_error", parity_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle_bits(2);

    // Short low glitch must be rejected at mid-start.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; b0 = n_busy;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_seen", (n_busy - b0) > 0, 1'b1);
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    chk("glitch_perr", n_perr - p0, 0);
    chk("glitch_rx_data", rx_data, 8'h00);
    chk("glitch_busy_after", busy, 1'b0);

    // 0xA5, good frame.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(3);
    chk("a5_valid_cnt", n_valid - v0, 1);
    chk("a5_pulse_data", vdata[v0 % 32], 8'hA5);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_busy", busy, 1'b0);
    chk("a5_ferr", n_ferr - f0, 0);
    chk("a5_perr", n_perr - p0, 0);
    lat = vcyc[v0 % 32] - fall_cyc;
    chk("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);

    // 0x3C with a low stop bit.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(3);
    chk("bad_stop_ferr", n_ferr - f0, 1);
    chk("bad_stop_valid", n_valid - v0, 0);
    chk("bad_stop_perr", n_perr - p0, 0);
    chk("bad_stop_rx_data", rx_data, 8'hA5);

    // 0x00 and 0xFF back to back.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(3);
    chk("b2b_valid_cnt", n_valid - v0, 2);
    chk("b2b_data0", vdata[v0 % 32], 8'h00);
    chk("b2b_data1", vdata[(v0 + 1) % 32], 8'hFF);
    gap = vcyc[(v0 + 1) % 32] - vcyc[v0 % 32];
    chk("b2b_gap", (gap >= NBITS * BD - 1 && gap <= NBITS * BD + 1) ? NBITS * BD : gap, NBITS * BD);
    chk("b2b_ferr", n_ferr - f0, 0);

    // Reset during data bit 4 of 0x77; the transmitter abandons that frame.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    d77 = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d77[i]);
    rx_serial = d77[4];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(20);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_bits(3);
    chk("abort_valid_cnt", n_valid - v0, 1);
    chk("abort_data", vdata[v0 % 32], 8'h5A);
    chk("abort_rx_data_after", rx_data, 8'h5A);
    chk("abort_ferr", n_ferr - f0, 0);
    chk("abort_perr", n_perr - p0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit is 1, so flipping sends 0.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(3);
    chk("par_bad_perr", n_perr - p0, 1);
    chk("par_bad_valid", n_valid - v0, 0);
    chk("par_bad_ferr", n_ferr - f0, 0);
    chk("par_bad_rx_data", rx_data, 8'h5A);
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(3);
    chk("par_good_valid", n_valid - v0, 1);
    chk("par_good_rx_data", rx_data, 8'h07);
    chk("par_good_perr", n_perr - p0, 0);
`endif

    chk("no_overlap", n_overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
